writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-side front end for the 32x32 register file: merges ALU results and load-return results onto the single register-file write port (write_reg, write_data, reg_write).
- Buffers ALU results in a small FIFO when a load return takes the port.
- Keeps a pending-destination scoreboard so decode can stall on registers not yet written.
- Sits between the execute/memory stages and the register file in the multicycle datapath.

Parameters:
- DEPTH, 4, ALU-result FIFO entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  FIFO can accept (combinational, = !full)
- ld_issue  in  1  load issued this cycle; marks ld_rd pending
- ld_rd  in  5  destination of the issued load
- mem_valid  in  1  load data returning (cannot be back-pressured)
- mem_rd  in  5  load-return destination
- mem_data  in  32  load-return data
- write_reg  out  5  to register file write_reg
- write_data  out  32  to register file write_data
- reg_write  out  1  to register file reg_write
- busy  out  32  busy[i]=1: register i has a write not yet on the port
- err  out  1  sticky: load return to a register with no pending load

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, load-pending bits 0, write_reg=0, write_data=0, reg_write=0, err=0; busy=0.
- ALU accept: handshake alu_valid && alu_ready; alu_rd=0 is accepted but discarded (not enqueued, never written).
- Port arbitration each cycle, registered outputs, latency 1 cycle:
  - mem_valid=1 with mem_rd!=0: load return wins; next cycle reg_write=1, write_reg=mem_rd, write_data=mem_data; FIFO head holds.
  - Otherwise, FIFO not empty: pop head; next cycle reg_write=1 with head rd/data.
  - Otherwise: reg_write=0; write_reg/write_data hold their last values.
- mem_valid with mem_rd=0: dropped, no write; does not block a FIFO pop.
- ALU bypass: an ALU result accepted into an empty FIFO in a cycle with no load return is written the next cycle. It enters and leaves the FIFO in the same cycle: count unchanged, 1-cycle latency.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Full: alu_ready=0 while count==DEPTH. A pop in the same cycle does NOT raise alu_ready; ready is based on registered count only.
- Load-pending bits:
  - ld_issue with ld_rd!=0 sets pend[ld_rd].
  - A load return registered to the port clears pend[mem_rd].
  - Same cycle, same register, both issue and return: set wins, because a new load is outstanding.
- busy[i] = pend[i] OR any valid FIFO entry with rd==i OR (reg_write && write_reg==i). It is combinational from state, and busy[0] is always 0.
- Errors: mem_valid with mem_rd!=0 and pend[mem_rd]=0 sets err, which stays set until reset. The write still proceeds.
- Reset mid-operation: queued ALU results and pending bits are lost. reg_write drops immediately (asynchronously).
- No write ordering between the two sources beyond this priority rule. Decode must not issue an ALU op whose rd is busy from a load (WAW is enforced by the busy stall upstream).

Test Plan:
- Single ALU write: alu_valid, rd=5, data=0x1234 into idle unit -> next cycle reg_write=1, write_reg=5, write_data=0x1234; busy[5]=1 for exactly that output cycle.
- Collision: same cycle alu rd=3 data=0xA and mem_valid rd=7 data=0xB, with pend[7] set -> cycle+1 writes r7=0xB, cycle+2 writes r3=0xA; busy[3] high during the wait.
- Fill FIFO: load returns every cycle while 5 ALU results are offered -> alu_ready falls after 4 accepted, the 5th is held. When returns stop: 4 writes in FIFO order, then the 5th.
- Scoreboard: ld_issue rd=9 -> busy[9]=1. Three cycles later mem_valid rd=9 data=0xDEAD -> write r9, busy[9]=0 the cycle after. Repeat with a same-cycle reissue of rd=9 -> busy[9] stays 1.
- x0 and err: ALU rd=0 and mem rd=0 -> no reg_write ever. mem_valid rd=12 with no prior issue -> err=1, r12 written, err stays 1.
- Async reset with 3 queued entries and pend[4] set: drop rst_n between edges -> reg_write=0 and busy=0 immediately. After release, no stale writes.

Source files
------------

// File: rtl/writeback_if.sv
// Bus bundle between execute/memory stages, the write-back arbiter and the register file.
// The arbiter connects through the slave modport; the stage driving ALU/load traffic uses master.
interface writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] busy;
    logic        err;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, mem_valid, mem_rd, mem_data,
        input  alu_ready, write_reg, write_data, reg_write, busy, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, mem_valid, mem_rd, mem_data,
        output alu_ready, write_reg, write_data, reg_write, busy, err
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results and load returns onto the single register-file write port,
// queueing ALU results behind load returns and tracking registers with writes in flight.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    writeback_if.slave  bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [4:0]       fifo_rd_r   [DEPTH];
    logic [31:0]      fifo_data_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [31:0]      pend_r;
    logic [4:0]       write_reg_r;
    logic [31:0]      write_data_r;
    logic             reg_write_r;
    logic             err_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             mem_win_s;
    logic             pop_s;
    logic             bypass_s;
    logic             enq_s;
    logic [31:0]      pend_set_s;
    logic [31:0]      pend_clr_s;
    logic [31:0]      pend_nxt_s;
    logic [PTR_W-1:0] ent_off_s   [DEPTH];
    logic [DEPTH-1:0] ent_valid_s;
    logic [31:0]      fifo_hit_s;
    logic [31:0]      wr_hit_s;
    logic [31:0]      busy_s;

    // Handshake and port arbitration decisions; readiness uses only the registered count.
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        empty_s   = (count_r == (PTR_W+1)'(0));
        push_s    = bus.alu_valid && !full_s && (bus.alu_rd != 5'd0);
        mem_win_s = bus.mem_valid && (bus.mem_rd != 5'd0);
        pop_s     = !mem_win_s && !empty_s;
        bypass_s  = push_s && empty_s && !mem_win_s;
        enq_s     = push_s && !bypass_s;
    end

    // ALU-result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int j = 0; j < DEPTH; j++) begin
                fifo_rd_r[j]   <= 5'd0;
                fifo_data_r[j] <= 32'd0;
            end
        end else begin
            if (enq_s) begin
                fifo_rd_r[wr_ptr_r]   <= bus.alu_rd;
                fifo_data_r[wr_ptr_r] <= bus.alu_data;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered write port: load return first, then FIFO head, then same-cycle bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= 5'd0;
            write_data_r <= 32'd0;
        end else if (mem_win_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= bus.mem_rd;
            write_data_r <= bus.mem_data;
        end else if (pop_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= fifo_rd_r[rd_ptr_r];
            write_data_r <= fifo_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= bus.alu_rd;
            write_data_r <= bus.alu_data;
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    // Pending-load update: a reissue in the same cycle as the return keeps the bit set.
    always_comb begin
        pend_clr_s = mem_win_s ? (32'd1 << bus.mem_rd) : 32'd0;
        pend_set_s = (bus.ld_issue && (bus.ld_rd != 5'd0)) ? (32'd1 << bus.ld_rd) : 32'd0;
        pend_nxt_s = (pend_r & ~pend_clr_s) | pend_set_s;
    end

    // Pending bits and the sticky unexpected-return flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 32'd0;
            err_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            if (mem_win_s && !pend_r[bus.mem_rd]) begin
                err_r <= 1'b1;
            end
        end
    end

    // Busy map: pending loads, queued ALU results and the write currently on the port.
    always_comb begin
        fifo_hit_s = 32'd0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_off_s[j]   = PTR_W'(j) - rd_ptr_r;
            ent_valid_s[j] = ({1'b0, ent_off_s[j]} < count_r);
            fifo_hit_s     = fifo_hit_s | (ent_valid_s[j] ? (32'd1 << fifo_rd_r[j]) : 32'd0);
        end
        wr_hit_s = reg_write_r ? (32'd1 << write_reg_r) : 32'd0;
        busy_s   = (pend_r | fifo_hit_s | wr_hit_s) & ~32'd1;
    end

    assign bus.alu_ready  = !full_s;
    assign bus.write_reg  = write_reg_r;
    assign bus.write_data = write_data_r;
    assign bus.reg_write  = reg_write_r;
    assign bus.busy       = busy_s;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: fixed vector table, corner-case sequences
// and random traffic, all compared against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    writeback_if bus ();

    writeback_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pend;
    logic        m_err;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        li;
        logic [4:0]  lrd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        erw;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        logic [31:0] ebusy;
        logic        eerr;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic li, input logic [4:0] lrd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.ld_issue  = li;
        bus.ld_rd     = lrd;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = mdata;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 32'd0;
        m_err  = 1'b0;
        m_rw   = 1'b0;
        m_wr   = 5'd0;
        m_wd   = 32'd0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = m_pend;
        foreach (q[i]) b[q[i].rd] = 1'b1;
        if (m_rw) b[m_wr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // One clock: predict from the current inputs, advance, compare every output.
    task automatic cycle();
        ent_t e;
        logic acc;
        check("alu_ready", {31'd0, bus.alu_ready}, {31'd0, q.size() < DEPTH});
        acc  = bus.alu_valid && (q.size() < DEPTH) && (bus.alu_rd != 5'd0);
        e.rd = bus.alu_rd;
        e.data = bus.alu_data;
        m_rw = 1'b0;
        if (bus.mem_valid && bus.mem_rd != 5'd0) begin
            m_rw = 1'b1;
            m_wr = bus.mem_rd;
            m_wd = bus.mem_data;
            if (!m_pend[bus.mem_rd]) m_err = 1'b1;
            m_pend[bus.mem_rd] = 1'b0;
            if (acc) q.push_back(e);
        end else begin
            if (acc) q.push_back(e);
            if (q.size() > 0) begin
                e = q.pop_front();
                m_rw = 1'b1;
                m_wr = e.rd;
                m_wd = e.data;
            end
        end
        if (bus.ld_issue && bus.ld_rd != 5'd0) m_pend[bus.ld_rd] = 1'b1;
        @(posedge clk);
        #1;
        check("reg_write", {31'd0, bus.reg_write}, {31'd0, m_rw});
        check("write_reg", {27'd0, bus.write_reg}, {27'd0, m_wr});
        check("write_data", bus.write_data, m_wd);
        check("err", {31'd0, bus.err}, {31'd0, m_err});
        check("busy", bus.busy, model_busy());
    endtask

    // Asynchronous reset asserted between edges, released one edge later.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int   idx;
        int   writes;
        logic rdy;
        logic [4:0] order[$];

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_reg_write", {31'd0, bus.reg_write}, 32'd0);
        check("reset_write_reg", {27'd0, bus.write_reg}, 32'd0);
        check("reset_write_data", bus.write_data, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_busy", bus.busy, 32'd0);
        check("reset_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        rst_n = 1'b1;

        // av ard adata li lrd mv mrd mdata | rw wr wd busy err
        vt[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'h1234,   32'h20,   1'b0};
        vt[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'h1234,   32'h0,    1'b0};
        vt[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'h1234,   32'h80,   1'b0};
        vt[3] = '{1'b1, 5'd3, 32'hA,    1'b0, 5'd0, 1'b1, 5'd7,  32'hB,      1'b1, 5'd7,  32'hB,      32'h88,   1'b0};
        vt[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'hA,      32'h8,    1'b0};
        vt[5] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd3,  32'hA,      32'h0,    1'b0};
        vt[6] = '{1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 1'b1, 5'd0,  32'h66,     1'b0, 5'd3,  32'hA,      32'h0,    1'b0};
        vt[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd12, 32'hC0FFEE, 1'b1, 5'd12, 32'hC0FFEE, 32'h1000, 1'b1};
        vt[8] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'hC0FFEE, 32'h0,    1'b1};

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].adata, vt[i].li, vt[i].lrd, vt[i].mv, vt[i].mrd, vt[i].mdata);
            cycle();
            check($sformatf("vec%0d_reg_write", i), {31'd0, bus.reg_write}, {31'd0, vt[i].erw});
            check($sformatf("vec%0d_write_reg", i), {27'd0, bus.write_reg}, {27'd0, vt[i].ewr});
            check($sformatf("vec%0d_write_data", i), bus.write_data, vt[i].ewd);
            check($sformatf("vec%0d_busy", i), bus.busy, vt[i].ebusy);
            check($sformatf("vec%0d_err", i), {31'd0, bus.err}, {31'd0, vt[i].eerr});
        end
        idle();
        mid_reset();

        // Fill: returns every cycle block the port while five ALU results are offered.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 5, 5'(10 + idx), 32'h100 + 32'(idx), 1'b0, 5'd0, 1'b1, 5'd25, 32'hF00 + 32'(c));
            rdy = bus.alu_ready;
            cycle();
            if (rdy && idx < 5) idx++;
        end
        check("fill_accepted", 32'(idx), 32'd4);
        check("fill_ready_low", {31'd0, bus.alu_ready}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            drive(idx < 5, 5'(10 + idx), 32'h100 + 32'(idx), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
            rdy = bus.alu_ready;
            cycle();
            if (rdy && idx < 5) idx++;
            if (bus.reg_write) order.push_back(bus.write_reg);
        end
        check("fill_write_count", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            check($sformatf("fill_order%0d", k), {27'd0, order[k]}, 32'(10 + k));
        idle();
        mid_reset();

        // Scoreboard: issue, return three cycles later, then a return with same-cycle reissue.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        cycle();
        check("sb_busy9_issue", {31'd0, bus.busy[9]}, 32'd1);
        idle();
        cycle();
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hDEAD);
        cycle();
        check("sb_write9_data", bus.write_data, 32'hDEAD);
        check("sb_busy9_inflight", {31'd0, bus.busy[9]}, 32'd1);
        idle();
        cycle();
        check("sb_busy9_clear", {31'd0, bus.busy[9]}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        cycle();
        idle();
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'hBEEF);
        cycle();
        idle();
        cycle();
        check("sb_busy9_reissue", {31'd0, bus.busy[9]}, 32'd1);
        check("sb_no_err", {31'd0, bus.err}, 32'd0);
        mid_reset();

        // Reset with three queued entries and a pending load, then no stale writes.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
        cycle();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'(20 + c), 32'h200 + 32'(c), 1'b0, 5'd0, 1'b1, 5'd25, 32'h300);
            cycle();
        end
        check("pre_rst_busy4", {31'd0, bus.busy[4]}, 32'd1);
        check("pre_rst_busy21", {31'd0, bus.busy[21]}, 32'd1);
        idle();
        mid_reset();
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (bus.reg_write) writes++;
        end
        check("no_stale_writes", 32'(writes), 32'd0);

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
